// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
// Shares the single-port data memory between the M-stage load/store unit (CPU)
// and the external bridge/debug port (EXT). One word access is granted per
// cycle with round-robin priority; the ack and read data return one cycle later.
// Optional build macro: DM_ARB_TRACE_EN prints a trace line for every CPU store.
module dm_access_arbiter #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,      // asynchronous, active-low

    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [3:0]        i_cpu_be,
    input  logic [31:0]       i_cpu_wdata,
    input  logic [31:0]       i_cpu_pc,
    output logic              o_cpu_gnt,
    output logic              o_cpu_stall,
    output logic              o_cpu_ack,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_err,

    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [3:0]        i_ext_be,
    input  logic [31:0]       i_ext_wdata,
    output logic              o_ext_gnt,
    output logic              o_ext_ack,
    output logic [31:0]       o_ext_rdata,
    output logic              o_ext_err,

    output logic [IDX_W-1:0]  o_mem_idx,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP_CPU,
        S_RESP_EXT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic r_last_ext;       // 1 when the most recent grant went to EXT
    logic r_resp_err;       // error status of the access now being acknowledged
    logic r_resp_we;        // access now being acknowledged was a store

    logic w_cpu_in_range;
    logic w_ext_in_range;
    logic w_cpu_be_ok;
    logic w_ext_be_ok;
    logic w_cpu_err;
    logic w_ext_err;

    logic w_cpu_win;
    logic w_ext_win;

    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [3:0]        w_sel_be;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_err;

    // A byte-enable pattern is legal only for the size and alignment it implies:
    // word at offset 0, halfword at offset 0 or 2, single byte at its own lane.
    function automatic logic be_matches(input logic [3:0] be, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (be)
            4'b1111: ok = (off == 2'd0);
            4'b0011: ok = (off == 2'd0);
            4'b1100: ok = (off == 2'd2);
            4'b0001: ok = (off == 2'd0);
            4'b0010: ok = (off == 2'd1);
            4'b0100: ok = (off == 2'd2);
            4'b1000: ok = (off == 2'd3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_cpu_in_range = (i_cpu_addr[ADDR_W-1:IDX_W+2] == '0);
    assign w_ext_in_range = (i_ext_addr[ADDR_W-1:IDX_W+2] == '0);
    assign w_cpu_be_ok    = be_matches(i_cpu_be, i_cpu_addr[1:0]);
    assign w_ext_be_ok    = be_matches(i_ext_be, i_ext_addr[1:0]);
    assign w_cpu_err      = ~w_cpu_in_range | ~w_cpu_be_ok;
    assign w_ext_err      = ~w_ext_in_range | ~w_ext_be_ok;

    // Round-robin choice: a lone requester wins, a tie goes to whoever was not
    // granted last; nothing is granted while reset is asserted
    always_comb begin
        w_cpu_win = i_reset & i_cpu_req & (~i_ext_req | r_last_ext);
        w_ext_win = i_reset & i_ext_req & (~i_cpu_req | ~r_last_ext);
    end

    assign o_cpu_gnt   = w_cpu_win;
    assign o_ext_gnt   = w_ext_win;
    assign o_cpu_stall = i_cpu_req & ~w_cpu_win;

    // Route the winning requester's access onto the DM port (all zero when idle)
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_be    = 4'b0000;
        w_sel_wdata = 32'h0;
        w_sel_err   = 1'b0;
        if (w_cpu_win) begin
            w_sel_we    = i_cpu_we;
            w_sel_addr  = i_cpu_addr;
            w_sel_be    = i_cpu_be;
            w_sel_wdata = i_cpu_wdata;
            w_sel_err   = w_cpu_err;
        end else if (w_ext_win) begin
            w_sel_we    = i_ext_we;
            w_sel_addr  = i_ext_addr;
            w_sel_be    = i_ext_be;
            w_sel_wdata = i_ext_wdata;
            w_sel_err   = w_ext_err;
        end
    end

    assign o_mem_idx   = w_sel_addr[IDX_W+1:2];
    assign o_mem_we    = w_sel_we & ~w_sel_err;
    assign o_mem_be    = o_mem_we ? w_sel_be : 4'b0000;
    assign o_mem_wdata = w_sel_wdata;

    // State register plus the round-robin history and the status of the issued access
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_last_ext <= 1'b1;
            r_resp_err <= 1'b0;
            r_resp_we  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_resp_err <= w_sel_err;
            r_resp_we  <= w_sel_we;
            if (w_cpu_win) begin
                r_last_ext <= 1'b0;
            end else if (w_ext_win) begin
                r_last_ext <= 1'b1;
            end
        end
    end

    // Next state follows this cycle's grant; response outputs decode the current state
    always_comb begin
        w_next_state = S_IDLE;
        o_cpu_ack    = 1'b0;
        o_cpu_err    = 1'b0;
        o_cpu_rdata  = 32'h0;
        o_ext_ack    = 1'b0;
        o_ext_err    = 1'b0;
        o_ext_rdata  = 32'h0;

        if (w_cpu_win) begin
            w_next_state = S_RESP_CPU;
        end else if (w_ext_win) begin
            w_next_state = S_RESP_EXT;
        end

        case (r_state)
            S_RESP_CPU: begin
                o_cpu_ack = 1'b1;
                o_cpu_err = r_resp_err;
                if (!r_resp_we && !r_resp_err) begin
                    o_cpu_rdata = i_mem_rdata;
                end
            end
            S_RESP_EXT: begin
                o_ext_ack = 1'b1;
                o_ext_err = r_resp_err;
                if (!r_resp_we && !r_resp_err) begin
                    o_ext_rdata = i_mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef DM_ARB_TRACE_EN
    logic              r_tr_valid;
    logic [31:0]       r_tr_pc;
    logic [ADDR_W-1:0] r_tr_addr;
    logic [3:0]        r_tr_be;
    logic [31:0]       r_tr_wdata;
    logic [31:0]       w_tr_merged;

    // Remember each issued CPU store; the DM hands back the pre-write word of
    // that index in the following cycle, which is what the merge needs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tr_valid <= 1'b0;
            r_tr_pc    <= 32'h0;
            r_tr_addr  <= '0;
            r_tr_be    <= 4'b0000;
            r_tr_wdata <= 32'h0;
        end else begin
            r_tr_valid <= w_cpu_win & i_cpu_we & ~w_cpu_err;
            r_tr_pc    <= i_cpu_pc;
            r_tr_addr  <= {i_cpu_addr[ADDR_W-1:2], 2'b00};
            r_tr_be    <= i_cpu_be;
            r_tr_wdata <= i_cpu_wdata;
        end
    end

    // Old word with the enabled lanes replaced by the store data
    always_comb begin
        w_tr_merged = i_mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (r_tr_be[b]) begin
                w_tr_merged[8*b +: 8] = r_tr_wdata[8*b +: 8];
            end
        end
    end

    // Emit one trace line per completed CPU store
    always_ff @(posedge i_clk) begin
        if (r_tr_valid) begin
            $display("%d@%h: *%h <= %h", $time, r_tr_pc, r_tr_addr, w_tr_merged);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^i_cpu_pc;
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter
// Directed scenarios followed by randomized CPU/EXT traffic. A behavioural model
// of the arbitration rules and of the memory contents predicts every output on
// every cycle; a small bench-side DM array serves the DUT's memory port.
module tb_dm_access_arbiter;

    localparam int DEPTH = 4096;

    logic        clk  = 1'b0;
    logic        rstN = 1'b0;

    logic        cpuReq, cpuWe;
    logic [31:0] cpuAddr, cpuWdata, cpuPc;
    logic [3:0]  cpuBe;
    logic        cpuGnt, cpuStall, cpuAck, cpuErr;
    logic [31:0] cpuRdata;

    logic        extReq, extWe;
    logic [31:0] extAddr, extWdata;
    logic [3:0]  extBe;
    logic        extGnt, extAck, extErr;
    logic [31:0] extRdata;

    logic [11:0] memIdx;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic [31:0] memRdata;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    dm_access_arbiter #(.ADDR_W(32), .IDX_W(12)) dut (
        .i_clk       (clk),
        .i_reset     (rstN),
        .i_cpu_req   (cpuReq),
        .i_cpu_we    (cpuWe),
        .i_cpu_addr  (cpuAddr),
        .i_cpu_be    (cpuBe),
        .i_cpu_wdata (cpuWdata),
        .i_cpu_pc    (cpuPc),
        .o_cpu_gnt   (cpuGnt),
        .o_cpu_stall (cpuStall),
        .o_cpu_ack   (cpuAck),
        .o_cpu_rdata (cpuRdata),
        .o_cpu_err   (cpuErr),
        .i_ext_req   (extReq),
        .i_ext_we    (extWe),
        .i_ext_addr  (extAddr),
        .i_ext_be    (extBe),
        .i_ext_wdata (extWdata),
        .o_ext_gnt   (extGnt),
        .o_ext_ack   (extAck),
        .o_ext_rdata (extRdata),
        .o_ext_err   (extErr),
        .o_mem_idx   (memIdx),
        .o_mem_we    (memWe),
        .o_mem_be    (memBe),
        .o_mem_wdata (memWdata),
        .i_mem_rdata (memRdata)
    );

    function automatic logic [31:0] initWord(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] laneMerge(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] be);
        logic [31:0] res;
        res = oldW;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = newW[8*b +: 8];
        end
        return res;
    endfunction

    // Legal access: inside 16 KiB, 1/2/4 contiguous lanes, naturally aligned,
    // lowest enabled lane equal to the byte offset of the address.
    function automatic bit accessErr(input logic [31:0] addr, input logic [3:0] be);
        int n;
        int low;
        logic [3:0] mask;
        if (addr[31:14] != 18'h0) return 1'b1;
        n = $countones(be);
        if (n != 1 && n != 2 && n != 4) return 1'b1;
        low = 0;
        while (!be[low]) low++;
        mask = 4'((1 << n) - 1) << low;
        if (mask != be) return 1'b1;
        if ((low % n) != 0) return 1'b1;
        return (low != int'(addr[1:0]));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Bench-side DM: read-first synchronous read, lane-masked write
    logic [31:0] dmMem [DEPTH];
    bit dmReady = 1'b0;
    always @(posedge clk) begin
        if (!dmReady) begin
            for (int i = 0; i < DEPTH; i++) dmMem[i] <= initWord(i);
            dmReady  <= 1'b1;
            memRdata <= 32'h0;
        end else begin
            memRdata <= dmMem[memIdx];
            if (memWe) dmMem[memIdx] <= laneMerge(dmMem[memIdx], memWdata, memBe);
        end
    end

    // Reference model state
    typedef struct packed {
        logic        valid;
        logic        toCpu;
        logic        err;
        logic [31:0] rdata;
        logic        doWrite;
        logic [11:0] idx;
        logic [3:0]  be;
        logic [31:0] wdata;
    } plan_t;

    logic [31:0] refMem [DEPTH];
    bit    refReady   = 1'b0;
    bit    lastWasCpu = 1'b0;
    plan_t curResp    = '0;
    plan_t nextResp   = '0;

    // Model commit: the access planned in the previous half-cycle takes effect at the edge
    always @(posedge clk or negedge rstN) begin
        if (!refReady) begin
            for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
            refReady = 1'b1;
        end
        if (!rstN) begin
            lastWasCpu = 1'b0;
            curResp    = '0;
        end else begin
            curResp = nextResp;
            if (nextResp.valid) lastWasCpu = nextResp.toCpu;
            if (nextResp.doWrite)
                refMem[nextResp.idx] = laneMerge(refMem[nextResp.idx], nextResp.wdata, nextResp.be);
        end
    end

    // Every-cycle comparison of DUT outputs against the model, then plan the next response
    always @(negedge clk) begin
        bit          expCpu, expExt, win, selWe, selErr, expWe;
        logic [31:0] selAddr, selWd;
        logic [3:0]  selBe;
        if (rstN) begin
            expCpu  = cpuReq && (!extReq || !lastWasCpu);
            expExt  = extReq && !expCpu;
            win     = expCpu || expExt;
            selAddr = expCpu ? cpuAddr  : extAddr;
            selWd   = expCpu ? cpuWdata : extWdata;
            selBe   = expCpu ? cpuBe    : extBe;
            selWe   = expCpu ? cpuWe    : extWe;
            selErr  = accessErr(selAddr, selBe);
            expWe   = win && selWe && !selErr;

            checkOutput("m_cpu_gnt",   32'(cpuGnt),   32'(expCpu));
            checkOutput("m_ext_gnt",   32'(extGnt),   32'(expExt));
            checkOutput("m_cpu_stall", 32'(cpuStall), 32'(cpuReq && !expCpu));
            checkOutput("m_mem_we",    32'(memWe),    32'(expWe));
            checkOutput("m_mem_be",    32'(memBe),    32'(expWe ? selBe : 4'b0000));
            if (win)   checkOutput("m_mem_idx",   32'(memIdx), 32'(selAddr[13:2]));
            if (expWe) checkOutput("m_mem_wdata", memWdata,    selWd);

            checkOutput("m_cpu_ack",   32'(cpuAck), 32'(curResp.valid && curResp.toCpu));
            checkOutput("m_cpu_err",   32'(cpuErr), 32'(curResp.valid && curResp.toCpu && curResp.err));
            checkOutput("m_cpu_rdata", cpuRdata,    (curResp.valid && curResp.toCpu) ? curResp.rdata : 32'h0);
            checkOutput("m_ext_ack",   32'(extAck), 32'(curResp.valid && !curResp.toCpu));
            checkOutput("m_ext_err",   32'(extErr), 32'(curResp.valid && !curResp.toCpu && curResp.err));
            checkOutput("m_ext_rdata", extRdata,    (curResp.valid && !curResp.toCpu) ? curResp.rdata : 32'h0);

            nextResp.valid   = win;
            nextResp.toCpu   = expCpu;
            nextResp.err     = selErr;
            nextResp.rdata   = (win && !selWe && !selErr) ? refMem[selAddr[13:2]] : 32'h0;
            nextResp.doWrite = expWe;
            nextResp.idx     = selAddr[13:2];
            nextResp.be      = selBe;
            nextResp.wdata   = selWd;
        end else begin
            nextResp = '0;
        end
    end

    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                                 input logic [3:0] cBe, input logic [31:0] cWd,
                                 input logic eReq, input logic eWe, input logic [31:0] eAddr,
                                 input logic [3:0] eBe, input logic [31:0] eWd);
        cpuReq   = cReq;
        cpuWe    = cWe;
        cpuAddr  = cAddr;
        cpuBe    = cBe;
        cpuWdata = cWd;
        cpuPc    = 32'h0000_1000 + cAddr;
        extReq   = eReq;
        extWe    = eWe;
        extAddr  = eAddr;
        extBe    = eBe;
        extWdata = eWd;
    endtask

    task automatic idleAll();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic randAccess(output logic we, output logic [31:0] addr,
                              output logic [3:0] be, output logic [31:0] wd);
        int sz;
        logic [1:0] off;
        sz = $urandom_range(0, 2);
        we = 1'($urandom_range(0, 1));
        wd = $urandom;
        case (sz)
            0:       begin off = 2'($urandom_range(0, 3)); be = 4'b0001 << off; end
            1:       begin off = {1'($urandom_range(0, 1)), 1'b0}; be = 4'b0011 << off; end
            default: begin off = 2'b00; be = 4'b1111; end
        endcase
        if ($urandom_range(0, 9) == 0) begin
            be  = 4'($urandom);
            off = 2'($urandom);
        end
        addr = {18'h0, 12'($urandom_range(0, 15)), off};
        if ($urandom_range(0, 19) == 0) addr[31:14] = 18'($urandom_range(1, 3));
    endtask

    initial begin
        logic [5:0] altPattern;
        logic cg, eg;
        logic rWe;
        logic [31:0] rAddr, rWd;
        logic [3:0] rBe;

        idleAll();
        rstN = 1'b0;
        repeat (2) nextCycle();

        // Reset state, with both ports already requesting
        applyStimulus(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("rst_cpu_gnt", 32'(cpuGnt), 32'd0);
        checkOutput("rst_ext_gnt", 32'(extGnt), 32'd0);
        checkOutput("rst_cpu_ack", 32'(cpuAck), 32'd0);
        checkOutput("rst_ext_ack", 32'(extAck), 32'd0);
        checkOutput("rst_mem_we",  32'(memWe),  32'd0);
        checkOutput("rst_mem_be",  32'(memBe),  32'd0);
        checkOutput("rst_mem_idx", 32'(memIdx), 32'd0);
        checkOutput("rst_cpu_rdata", cpuRdata,  32'h0);
        nextCycle();
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("first_cpu_gnt", 32'(cpuGnt), 32'd1);
        checkOutput("first_ext_gnt", 32'(extGnt), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("second_ext_gnt", 32'(extGnt), 32'd1);
        checkOutput("second_cpu_ack", 32'(cpuAck), 32'd1);
        nextCycle();
        idleAll();
        @(negedge clk);
        checkOutput("third_ext_ack",   32'(extAck), 32'd1);
        checkOutput("third_ext_rdata", extRdata,    initWord(8));

        // Store word then load it back
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("sw_cpu_gnt",   32'(cpuGnt),   32'd1);
        checkOutput("sw_cpu_stall", 32'(cpuStall), 32'd0);
        checkOutput("sw_mem_we",    32'(memWe),    32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("lw_cpu_stall", 32'(cpuStall), 32'd0);
        checkOutput("sw_cpu_ack",   32'(cpuAck),   32'd1);
        nextCycle();
        idleAll();
        @(negedge clk);
        checkOutput("lw_cpu_ack",   32'(cpuAck), 32'd1);
        checkOutput("lw_cpu_rdata", cpuRdata,    32'h1234_5678);

        // Byte store into lane 2 over an all-ones word
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h22, 4'b0100, 32'h00AB_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("sb_mem_be", 32'(memBe), 32'b0100);
        checkOutput("sb_mem_we", 32'(memWe), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        nextCycle();
        idleAll();
        @(negedge clk);
        checkOutput("sb_lw_ack",   32'(cpuAck), 32'd1);
        checkOutput("sb_lw_rdata", cpuRdata,    32'hFFAB_FFFF);

        // Out-of-range EXT load
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h4000, 4'hF, 32'h0);
        @(negedge clk);
        checkOutput("oor_ext_gnt", 32'(extGnt), 32'd1);
        checkOutput("oor_mem_we",  32'(memWe),  32'd0);
        nextCycle();
        idleAll();
        @(negedge clk);
        checkOutput("oor_ext_ack",   32'(extAck), 32'd1);
        checkOutput("oor_ext_err",   32'(extErr), 32'd1);
        checkOutput("oor_ext_rdata", extRdata,    32'h0);
        checkOutput("oor_mem_we2",   32'(memWe),  32'd0);

        // Continuous requests from both ports alternate C,E,C,E,C,E
        altPattern = 6'b010101;
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 1'b0, 32'h34, 4'hF, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("alt_cpu_gnt",   32'(cpuGnt),   32'(altPattern[k]));
            checkOutput("alt_ext_gnt",   32'(extGnt),   32'(!altPattern[k]));
            checkOutput("alt_cpu_stall", 32'(cpuStall), 32'(!altPattern[k]));
            nextCycle();
        end
        idleAll();

        // Reset while a CPU response is in flight
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checkOutput("mid_cpu_gnt", 32'(cpuGnt), 32'd1);
        nextCycle();
        idleAll();
        #1 rstN = 1'b0;
        #1;
        checkOutput("mid_rst_cpu_ack",   32'(cpuAck), 32'd0);
        checkOutput("mid_rst_cpu_rdata", cpuRdata,    32'h0);
        applyStimulus(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
        nextCycle();
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_cpu_gnt", 32'(cpuGnt), 32'd1);
        checkOutput("post_rst_ext_gnt", 32'(extGnt), 32'd0);
        checkOutput("post_rst_no_ack",  32'(cpuAck), 32'd0);
        nextCycle();
        idleAll();

        // Randomized traffic: requests held until granted, occasionally withdrawn
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            cg = cpuGnt;
            eg = extGnt;
            nextCycle();
            if (cpuReq && !cg) begin
                if ($urandom_range(0, 19) == 0) cpuReq = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                randAccess(rWe, rAddr, rBe, rWd);
                cpuReq = 1'b1; cpuWe = rWe; cpuAddr = rAddr; cpuBe = rBe; cpuWdata = rWd;
                cpuPc = $urandom;
            end else begin
                cpuReq = 1'b0;
            end
            if (extReq && !eg) begin
                if ($urandom_range(0, 19) == 0) extReq = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                randAccess(rWe, rAddr, rBe, rWd);
                extReq = 1'b1; extWe = rWe; extAddr = rAddr; extBe = rBe; extWdata = rWd;
            end else begin
                extReq = 1'b0;
            end
        end
        idleAll();
        repeat (3) nextCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
